host_spi_frame_rx: RTL and testbench

Parametrised receiver for host control frames arriving on the module serial link (frame enable, serial clock, serial data, already converted to single-ended by the pad buffers). It oversamples the link in the `clk_in` domain, assembles fixed-length frames, checks framing, and buffers complete frames in a small FIFO. The downstream channel-SPI scheduler consumes frames over a valid/ready handshake. It replaces the fixed 24-bit, unbuffered front end and adds:
- configurable frame length;
- back-to-back frames under a continuously low enable;
- an idle timeout;
- error reporting.

---
 rtl/host_spi_frame_rx_if.sv | 25 ++
 rtl/host_spi_frame_rx.sv | 248 ++++++++++++++++++++++++
 tb/tb_host_spi_frame_rx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_spi_frame_rx_if.sv
// Frame handshake bus between the host SPI frame receiver (master, source of
// frames) and the downstream channel-SPI scheduler (slave, consumer).
interface host_spi_frame_rx_if #(
    parameter int FRAME_BITS = 24,
    parameter int FIFO_DEPTH = 4
);
    logic [FRAME_BITS-1:0]         frm_data;
    logic                          frm_valid;
    logic                          frm_ready;
    logic [$clog2(FIFO_DEPTH):0]   frm_level;

    modport master (
        output frm_data,
        output frm_valid,
        output frm_level,
        input  frm_ready
    );

    modport slave (
        input  frm_data,
        input  frm_valid,
        input  frm_level,
        output frm_ready
    );
endinterface

// File: rtl/host_spi_frame_rx.sv
// host_spi_frame_rx: oversampling receiver for host control frames on the
// serial link (enable / clock / data). Synchronises the link into i_clk_in,
// assembles MSB-first frames, discards short or stalled frames, and buffers
// complete frames in a first-word fall-through FIFO behind a valid/ready bus.
// Optional feature macro: FRAME_PARITY_EN (adds one odd-parity bit per frame).
module host_spi_frame_rx #(
    parameter int FRAME_BITS   = 24,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  i_clk_in,
    input  logic                  i_rst,
    input  logic                  i_spi_en_n,
    input  logic                  i_spi_sclk,
    input  logic                  i_spi_sdo,
    host_spi_frame_rx_if.master   frm_if,
    output logic                  o_busy,
    output logic                  o_err_short,
    output logic                  o_err_overflow,
    output logic                  o_err_parity
);

`ifdef FRAME_PARITY_EN
    localparam int NBITS = FRAME_BITS + 1;
`else
    localparam int NBITS = FRAME_BITS;
`endif
    localparam int CW = $clog2(NBITS + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

`ifdef FRAME_PARITY_EN
    // Odd parity: payload plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [NBITS-1:0] f);
        odd_parity_ok = ^f;
    endfunction
`endif

    // ---------------- link conditioning ----------------
    logic [SYNC_STAGES-1:0] r_sync_en;
    logic [SYNC_STAGES-1:0] r_sync_sclk;
    logic [SYNC_STAGES-1:0] r_sync_sdo;
    logic                   r_sclk_d;
    logic                   r_en_d;

    logic w_en_n;
    logic w_sclk;
    logic w_sdo;
    logic w_rise;
    logic w_en_rise;

    // Synchronise the three asynchronous link inputs and keep previous values for edge detection.
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_sync_en   <= {SYNC_STAGES{1'b0}};
            r_sync_sclk <= {SYNC_STAGES{1'b0}};
            r_sync_sdo  <= {SYNC_STAGES{1'b0}};
            r_sclk_d    <= 1'b0;
            r_en_d      <= 1'b0;
        end else begin
            r_sync_en   <= {r_sync_en[SYNC_STAGES-2:0],   i_spi_en_n};
            r_sync_sclk <= {r_sync_sclk[SYNC_STAGES-2:0], i_spi_sclk};
            r_sync_sdo  <= {r_sync_sdo[SYNC_STAGES-2:0],  i_spi_sdo};
            r_sclk_d    <= w_sclk;
            r_en_d      <= w_en_n;
        end
    end

    // Edge detection on the synchronised serial clock and enable.
    always_comb begin
        w_en_n    = r_sync_en[SYNC_STAGES-1];
        w_sclk    = r_sync_sclk[SYNC_STAGES-1];
        w_sdo     = r_sync_sdo[SYNC_STAGES-1];
        w_rise    = w_sclk & ~r_sclk_d;
        w_en_rise = w_en_n & ~r_en_d;
    end

    // ---------------- frame assembly ----------------
    logic [CW-1:0]    r_cnt;
    logic [NBITS-1:0] r_shift;
    logic [IW-1:0]    r_idle;
    logic             r_busy;

    logic [CW-1:0]    w_cnt_next;
    logic [NBITS-1:0] w_shift_next;
    logic [IW-1:0]    w_idle_next;
    logic             w_frame_done;
    logic             w_abort;
    logic             w_timeout;
    logic             w_parity_ok;

    // Bit counter / shifter next state; an enable release beats a same-cycle clock edge.
    always_comb begin
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_frame_done = 1'b0;
        w_abort      = 1'b0;
        w_timeout    = (r_cnt != {CW{1'b0}}) && (r_idle == IW'(IDLE_TIMEOUT));
        if (w_en_rise && (r_cnt != {CW{1'b0}})) begin
            w_cnt_next = {CW{1'b0}};
            w_abort    = 1'b1;
        end else if (w_rise && !w_en_n) begin
            w_shift_next = {r_shift[NBITS-2:0], w_sdo};
            if (r_cnt == CW'(NBITS - 1)) begin
                w_cnt_next   = {CW{1'b0}};
                w_frame_done = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end else if (w_timeout) begin
            w_cnt_next = {CW{1'b0}};
            w_abort    = 1'b1;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Idle counter: held at zero between frames and restarted by every serial clock edge.
    always_comb begin
        if (w_rise || (r_cnt == {CW{1'b0}}) || w_timeout) begin
            w_idle_next = {IW{1'b0}};
        end else begin
            w_idle_next = r_idle + IW'(1);
        end
    end

    // Frame check result for the frame completing this cycle.
    always_comb begin
`ifdef FRAME_PARITY_EN
        w_parity_ok = odd_parity_ok(w_shift_next);
`else
        w_parity_ok = 1'b1;
`endif
    end

    // Assembly state registers.
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_cnt   <= {CW{1'b0}};
            r_shift <= {NBITS{1'b0}};
            r_idle  <= {IW{1'b0}};
            r_busy  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_idle  <= w_idle_next;
            r_busy  <= (w_cnt_next != {CW{1'b0}});
        end
    end

    // ---------------- push stage ----------------
    logic                  r_push;
    logic [FRAME_BITS-1:0] r_push_data;
    logic                  r_err_short;

    // Register the completed payload; the FIFO write happens one cycle later.
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_push      <= 1'b0;
            r_push_data <= {FRAME_BITS{1'b0}};
            r_err_short <= 1'b0;
        end else begin
            r_push      <= w_frame_done & w_parity_ok;
            r_push_data <= w_shift_next[NBITS-1 -: FRAME_BITS];
            r_err_short <= w_abort;
        end
    end

`ifdef FRAME_PARITY_EN
    logic r_err_parity;

    // Parity failure pulse, aligned with the cycle the push would have been presented.
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_err_parity <= 1'b0;
        end else begin
            r_err_parity <= w_frame_done & ~w_parity_ok;
        end
    end

    assign o_err_parity = r_err_parity;
`else
    assign o_err_parity = 1'b0;
`endif

    // ---------------- FIFO ----------------
    logic [FRAME_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_valid;
    logic                  r_err_ovf;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic [LW-1:0]         w_level_next;

    // Handshake decode: a pop frees a slot for a same-cycle push into a full FIFO.
    always_comb begin
        w_full = (r_level == LW'(FIFO_DEPTH));
        w_pop  = r_valid & frm_if.frm_ready;
        w_wr   = r_push & (~w_full | w_pop);
        case ({w_wr, w_pop})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    // FIFO pointers, occupancy, valid flag and overflow pulse.
    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_wr_ptr  <= {PW{1'b0}};
            r_rd_ptr  <= {PW{1'b0}};
            r_level   <= {LW{1'b0}};
            r_valid   <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level   <= w_level_next;
            r_valid   <= (w_level_next != {LW{1'b0}});
            r_err_ovf <= r_push & w_full & ~w_pop;
        end
    end

    // Frame storage; contents are only observable while valid.
    always_ff @(posedge i_clk_in) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    assign frm_if.frm_data  = r_valid ? r_mem[r_rd_ptr] : {FRAME_BITS{1'b0}};
    assign frm_if.frm_valid = r_valid;
    assign frm_if.frm_level = r_level;
    assign o_busy           = r_busy;
    assign o_err_short      = r_err_short;
    assign o_err_overflow   = r_err_ovf;

endmodule

// File: tb/tb_host_spi_frame_rx.sv
// Directed testbench for host_spi_frame_rx: back-to-back frames, short frame,
// idle timeout, FIFO overflow and full-with-pop, reset mid-frame, and (with
// FRAME_PARITY_EN) parity accept/reject.
module tb_host_spi_frame_rx;

`ifdef FRAME_PARITY_EN
    localparam int NB = 25;
`else
    localparam int NB = 24;
`endif

    logic clk = 1'b0;
    logic rst;
    logic en_n;
    logic sclk;
    logic sdo;
    logic busy;
    logic err_short;
    logic err_ovf;
    logic err_par;

    host_spi_frame_rx_if #(.FRAME_BITS(24), .FIFO_DEPTH(4)) u_if ();

    host_spi_frame_rx #(
        .FRAME_BITS(24), .FIFO_DEPTH(4), .IDLE_TIMEOUT(1024), .SYNC_STAGES(2)
    ) dut (
        .i_clk_in       (clk),
        .i_rst          (rst),
        .i_spi_en_n     (en_n),
        .i_spi_sclk     (sclk),
        .i_spi_sdo      (sdo),
        .frm_if         (u_if.master),
        .o_busy         (busy),
        .o_err_short    (err_short),
        .o_err_overflow (err_ovf),
        .o_err_parity   (err_par)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_short = 0;
    int n_ovf   = 0;
    int n_par   = 0;
    int n_coinc = 0;
    logic [23:0] q[$];

    // Monitor: record popped frames and error pulses mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.frm_valid && u_if.frm_ready) q.push_back(u_if.frm_data);
            if (err_short) n_short++;
            if (err_ovf)   n_ovf++;
            if (err_par)   n_par++;
            if (err_short && err_ovf) n_coinc++;
        end
    end

    initial begin
        #200us;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sclk = 1'b0;
            sdo  = v[i];
            step(2);
            sclk = 1'b1;
            step(2);
        end
    endtask

    function automatic logic [31:0] frame_bits(input logic [23:0] d);
`ifdef FRAME_PARITY_EN
        frame_bits = {7'b0, d, ~^d};
`else
        frame_bits = {8'b0, d};
`endif
    endfunction

    task automatic send_frame(input logic [23:0] d);
        send_bits(frame_bits(d), NB);
    endtask

    initial begin
        logic [31:0] fv;
        int          ns;

        rst = 1'b1; en_n = 1'b1; sclk = 1'b0; sdo = 1'b0;
        u_if.frm_ready = 1'b0;
        step(3);
        @(negedge clk);
        chk("rst_valid", {31'b0, u_if.frm_valid}, 32'd0);
        chk("rst_level", {29'b0, u_if.frm_level}, 32'd0);
        chk("rst_data",  {8'b0, u_if.frm_data}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_errs",  {29'b0, err_short, err_ovf, err_par}, 32'd0);
        step(1);
        rst = 1'b0;
        step(5);
        en_n = 1'b0;
        u_if.frm_ready = 1'b1;
        step(3);

        // Back-to-back frames under a continuously low enable.
        send_frame(24'h00000A);
        step(400);
        send_frame(24'h20000B);
        step(10);
        @(negedge clk);
        chk("b2b_count", q.size(), 32'd2);
        chk("b2b_first", {8'b0, q[0]}, 32'h00000A);
        chk("b2b_second", {8'b0, q[1]}, 32'h20000B);
        chk("b2b_errs", n_short + n_ovf + n_par, 32'd0);
        chk("b2b_level", {29'b0, u_if.frm_level}, 32'd0);
        q.delete();

        // Short frame: 10 bits then enable released.
        step(1);
        send_bits(32'h2A5, 10);
        @(negedge clk);
        chk("short_busy_mid", {31'b0, busy}, 32'd1);
        step(1);
        en_n = 1'b1;
        step(6);
        @(negedge clk);
        chk("short_pulse", n_short, 32'd1);
        chk("short_busy_end", {31'b0, busy}, 32'd0);
        chk("short_level", {29'b0, u_if.frm_level}, 32'd0);
        step(1);
        en_n = 1'b0;
        step(4);
        send_frame(24'h5A5A5A);
        step(10);
        @(negedge clk);
        chk("after_short_count", q.size(), 32'd1);
        chk("after_short_data", {8'b0, q[0]}, 32'h5A5A5A);
        q.delete();

        // Idle timeout with enable held low.
        step(1);
        send_bits(32'h3C3, 10);
        step(1000);
        @(negedge clk);
        chk("idle_no_early", n_short, 32'd1);
        chk("idle_busy_mid", {31'b0, busy}, 32'd1);
        step(100);
        @(negedge clk);
        chk("idle_pulse", n_short, 32'd2);
        chk("idle_busy_end", {31'b0, busy}, 32'd0);
        step(1);
        send_frame(24'h123456);
        step(10);
        @(negedge clk);
        chk("after_idle_count", q.size(), 32'd1);
        chk("after_idle_data", {8'b0, q[0]}, 32'h123456);
        q.delete();

        // Overflow: five frames into a four-deep FIFO with no consumer.
        step(1);
        u_if.frm_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(24'(i) * 24'h111111);
        step(10);
        @(negedge clk);
        chk("ovf_level", {29'b0, u_if.frm_level}, 32'd4);
        chk("ovf_pulse", n_ovf, 32'd1);
        chk("ovf_head", {8'b0, u_if.frm_data}, 32'h111111);

        // Push coinciding with a pop while full: level stays, no error.
        step(1);
        fv = frame_bits(24'h666666);
        send_bits(fv >> 1, NB - 1);
        sclk = 1'b0;
        sdo  = fv[0];
        step(2);
        sclk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (!busy) begin
                u_if.frm_ready = 1'b1;
                break;
            end
        end
        step(1);
        u_if.frm_ready = 1'b0;
        @(negedge clk);
        chk("full_pop_level", {29'b0, u_if.frm_level}, 32'd4);
        chk("full_pop_no_ovf", n_ovf, 32'd1);
        chk("full_pop_head", {8'b0, u_if.frm_data}, 32'h222222);
        chk("full_pop_popped", {8'b0, q[0]}, 32'h111111);
        step(1);
        u_if.frm_ready = 1'b1;
        step(10);
        @(negedge clk);
        chk("drain_count", q.size(), 32'd5);
        chk("drain_second", {8'b0, q[1]}, 32'h222222);
        chk("drain_fourth", {8'b0, q[3]}, 32'h444444);
        chk("drain_last", {8'b0, q[4]}, 32'h666666);
        chk("drain_level", {29'b0, u_if.frm_level}, 32'd0);
        q.delete();

        // Reset mid-frame after 12 bits.
        step(1);
        ns = n_short;
        send_bits(32'hABC, 12);
        rst  = 1'b1;
        sclk = 1'b0;
        step(2);
        @(negedge clk);
        chk("rmid_busy", {31'b0, busy}, 32'd0);
        chk("rmid_valid", {31'b0, u_if.frm_valid}, 32'd0);
        chk("rmid_errs", {29'b0, err_short, err_ovf, err_par}, 32'd0);
        step(1);
        rst = 1'b0;
        step(5);
        @(negedge clk);
        chk("rmid_no_pulse", n_short, ns);
        step(1);
        send_frame(24'hABCDEF);
        step(10);
        @(negedge clk);
        chk("rmid_count", q.size(), 32'd1);
        chk("rmid_data", {8'b0, q[0]}, 32'hABCDEF);
        q.delete();

`ifdef FRAME_PARITY_EN
        // Parity: good parity accepted, bad parity dropped with a pulse.
        step(1);
        send_bits({7'b0, 24'h00000A, 1'b1}, 25);
        step(10);
        @(negedge clk);
        chk("par_good_count", q.size(), 32'd1);
        chk("par_good_data", {8'b0, q[0]}, 32'h00000A);
        chk("par_good_nopulse", n_par, 32'd0);
        step(1);
        send_bits({7'b0, 24'h00000A, 1'b0}, 25);
        step(10);
        @(negedge clk);
        chk("par_bad_pulse", n_par, 32'd1);
        chk("par_bad_nopush", q.size(), 32'd1);
        chk("par_bad_no_ovf", n_ovf, 32'd1);
`else
        chk("par_tied_off", n_par, 32'd0);
`endif

        chk("no_coincident_errs", n_coinc, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
